add_accumulator: RTL and testbench

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

---
 rtl/add_acc_pkg.sv | 7 +
 rtl/sample_counter.sv | 19 +
 rtl/add_accumulator.sv | 65 ++++++
 tb/tb_add_accumulator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/add_acc_pkg.sv
// add_acc_pkg: shared state encoding, counter width and default widths for add_accumulator
package add_acc_pkg;
   localparam int CNT_W = 4;
   localparam int DEF_WIDTH = 4;
   localparam int DEF_ACC_W = 8;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sample_counter.sv
// sample_counter: loadable down counter tracking how many adder results remain in a batch
module sample_counter
   import add_acc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] din,
   output logic [CNT_W-1:0] q,
   output logic             zero
);
   assign zero = q == '0;
   // load has priority over decrement; reset clears the count
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (load) q <= din;
      else if (dec) q <= q - CNT_W'(1);
endmodule

// File: rtl/add_accumulator.sv
// add_accumulator: sums N {cout,sum} results from an upstream adder per batch; ADD_ACC_SAT_EN selects saturation instead of wrap
module add_accumulator
   import add_acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_cout,
   output logic             in_ready,
   output logic [ACC_W-1:0] acc,
   output logic             acc_valid,
   output logic             busy,
   output logic             ovf
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] remaining;
   logic             rem_zero, hs, accept, last;
   logic [ACC_W-1:0] addend, acc_nx;
   logic [ACC_W:0]   sum;
   assign in_ready  = state == ACCUM;
   assign busy      = state != IDLE;
   assign acc_valid = state == DONE;
   assign hs        = in_valid & in_ready;
   assign accept    = (state == IDLE) & start;
   assign last      = hs & (remaining == CNT_W'(1));
   assign addend    = ACC_W'({in_cout, in_sum});
   assign sum       = {1'b0, acc} + {1'b0, addend};
`ifdef ADD_ACC_SAT_EN
   assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
   assign acc_nx = sum[ACC_W-1:0];
`endif
   sample_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .dec  (hs),
      .din  (count),
      .q    (remaining),
      .zero (rem_zero)
   );
   // next state; an empty counter in ACCUM also exits so the FSM can never stall
   always_comb
      state_nx = (state == IDLE)  ? (start ? ((count != '0) ? ACCUM : DONE) : IDLE) :
                 (state == ACCUM) ? ((last | rem_zero) ? DONE : ACCUM) : IDLE;
   // state register
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // accumulator and sticky overflow: cleared on accepted start, updated per handshake
   always_ff @(posedge clk)
      if (rst || accept) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (hs) begin
         acc <= acc_nx;
         ovf <= ovf | sum[ACC_W];
      end
endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: directed table-driven and sequence checks for add_accumulator
module tb_add_accumulator;
   logic       clk = 0, rst = 1, start = 0, in_valid = 0, in_cout = 0;
   logic [3:0] count = 0, in_sum = 0;
   logic       in_ready, acc_valid, busy, ovf;
   logic [7:0] acc;
   int n_cmp = 0, n_err = 0;

   add_accumulator dut (
      .clk(clk), .rst(rst), .start(start), .count(count), .in_valid(in_valid),
      .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready), .acc(acc),
      .acc_valid(acc_valid), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       cnt;
      logic [15:0][4:0] vals;
      int               gap;
      logic [7:0]       exp_acc;
      logic             exp_ovf;
   } vec_t;
   vec_t tv[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] c);
      start = 1;
      count = c;
      step();
      start = 0;
      count = 0;
   endtask

   task automatic present(input logic [4:0] v, input int gap);
      for (int g = 0; g < gap; g++) begin
         in_valid = 0;
         step();
         chk("idle_ready", in_ready, 1);
      end
      in_valid = 1;
      in_cout = v[4];
      in_sum = v[3:0];
      chk("ready_before_hs", in_ready, 1);
      step();
      in_valid = 0;
   endtask

   task automatic check_done(input string tag, input logic [7:0] ea, input logic eo);
      chk({tag, "_valid"}, acc_valid, 1);
      chk({tag, "_acc"}, acc, ea);
      chk({tag, "_ovf"}, ovf, eo);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_noready"}, in_ready, 0);
      step();
      chk({tag, "_pulse_end"}, acc_valid, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_hold_acc"}, acc, ea);
      chk({tag, "_hold_ovf"}, ovf, eo);
   endtask

   task automatic run_vec(input vec_t v);
      do_start(v.cnt);
      for (int i = 0; i < int'(v.cnt); i++) begin
         present(v.vals[i], v.gap);
         if (i < int'(v.cnt) - 1) chk("early_done", acc_valid, 0);
      end
      check_done("vec", v.exp_acc, v.exp_ovf);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin
         tv[k].vals = '0;
         tv[k].gap = 0;
         tv[k].exp_ovf = 0;
      end
      tv[0].cnt = 3; tv[0].vals[0] = 5; tv[0].vals[1] = 31; tv[0].vals[2] = 2; tv[0].exp_acc = 38;
      tv[1].cnt = 9; for (int i = 0; i < 9; i++) tv[1].vals[i] = 31; tv[1].exp_ovf = 1;
`ifdef ADD_ACC_SAT_EN
      tv[1].exp_acc = 255;
`else
      tv[1].exp_acc = 23;
`endif
      tv[2].cnt = 2; tv[2].vals[0] = 4; tv[2].vals[1] = 22; tv[2].gap = 3; tv[2].exp_acc = 26;
      tv[3].cnt = 8; for (int i = 0; i < 8; i++) tv[3].vals[i] = 31; tv[3].exp_acc = 248;
      tv[4].cnt = 9; for (int i = 0; i < 8; i++) tv[4].vals[i] = 31; tv[4].vals[8] = 8; tv[4].exp_ovf = 1;
`ifdef ADD_ACC_SAT_EN
      tv[4].exp_acc = 255;
`else
      tv[4].exp_acc = 0;
`endif
      tv[5].cnt = 1; tv[5].vals[0] = 17; tv[5].exp_acc = 17;
      tv[6].cnt = 10; for (int i = 0; i < 9; i++) tv[6].vals[i] = 31; tv[6].vals[9] = 1; tv[6].exp_ovf = 1;
`ifdef ADD_ACC_SAT_EN
      tv[6].exp_acc = 255;
`else
      tv[6].exp_acc = 24;
`endif
      tv[7].cnt = 15; for (int i = 0; i < 15; i++) tv[7].vals[i] = 1; tv[7].gap = 1; tv[7].exp_acc = 15;

      step();
      step();
      chk("rst_acc", acc, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", acc_valid, 0);
      rst = 0;
      step();

      for (int k = 0; k < 8; k++) run_vec(tv[k]);

      do_start(0);
      chk("zero_noready", in_ready, 0);
      check_done("zero", 0, 0);

      do_start(2);
      start = 1;
      count = 5;
      present(5'd3, 0);
      start = 0;
      count = 0;
      chk("restart_ignored_busy", busy, 1);
      chk("restart_ignored_acc", acc, 3);
      present(5'd17, 0);
      start = 1;
      count = 1;
      chk("ign_valid", acc_valid, 1);
      chk("ign_acc", acc, 20);
      step();
      start = 0;
      count = 0;
      chk("done_start_ignored", busy, 0);
      chk("done_start_acc", acc, 20);

      do_start(4);
      present(5'd7, 0);
      present(5'd9, 0);
      chk("mid_acc", acc, 16);
      rst = 1;
      start = 1;
      count = 3;
      in_valid = 1;
      in_sum = 4'd5;
      step();
      rst = 0;
      start = 0;
      count = 0;
      in_valid = 0;
      chk("midrst_acc", acc, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", in_ready, 0);
      chk("midrst_valid", acc_valid, 0);
      chk("midrst_ovf", ovf, 0);
      do_start(1);
      present(5'd1, 0);
      check_done("after_rst", 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
